// File: rtl/mem_access_seq.sv
// Memory access sequencer: orders MAR load, MDR enable/select and memory strobes around the ready handshake.
// Optional wait-state timeout is enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_access_seq #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear_n,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ready,
    output logic mar_in,
    output logic mdr_in,
    output logic mdr_read,
    output logic mem_read,
    output logic mem_write,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE, LOAD_MAR, WR_MDR, RD_WAIT, RD_CAP, WR_WAIT, DONE
    } state_t;

    state_t state, nxt;
    logic   op_wr;
    logic   to_hit;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // The wait cycle that would bring the counter to TIMEOUT is the last one allowed.
    assign to_hit = !mem_ready && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if ((nxt == RD_WAIT || nxt == WR_WAIT) && state == nxt) begin
                if (cnt != CW'(TIMEOUT))
                    cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state == IDLE && (rd_req || wr_req))
                err <= 1'b0;
            else if ((state == RD_WAIT || state == WR_WAIT) && to_hit)
                err <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (rd_req || wr_req) nxt = LOAD_MAR;
            LOAD_MAR: nxt = op_wr ? WR_MDR : RD_WAIT;
            WR_MDR:   nxt = WR_WAIT;
            RD_WAIT:  if (mem_ready) nxt = RD_CAP;
                      else if (to_hit) nxt = DONE;
            RD_CAP:   nxt = DONE;
            WR_WAIT:  if (mem_ready || to_hit) nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            mar_in    <= 1'b0;
            mdr_in    <= 1'b0;
            mdr_read  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && (rd_req || wr_req))
                op_wr <= !rd_req;
            mar_in    <= (nxt == LOAD_MAR);
            mdr_in    <= (nxt == WR_MDR) || (nxt == RD_CAP);
            mdr_read  <= (nxt == RD_CAP);
            mem_read  <= (nxt == RD_WAIT) || (nxt == RD_CAP);
            mem_write <= (nxt == WR_WAIT);
            busy      <= (nxt != IDLE);
            done      <= (nxt == DONE);
        end
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer for the mini CPU datapath. On a read or write request from the control unit it drives the MAR load enable, the MDR enable and MDR read-select, and the memory read/write strobes in a fixed order. It waits on the memory ready handshake and returns a one-cycle done pulse. It sits between the control unit, the MAR/MDR registers and the external memory.

## Interface
Parameters:
- TIMEOUT, 15: maximum number of consecutive wait cycles with mem_ready low before the access is aborted. Legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request from the control unit; level, sampled only in IDLE.
- wr_req  in  1  write request from the control unit; level, sampled only in IDLE.
- mem_ready  in  1  memory handshake; high means read data is valid or write data has been accepted.
- mar_in  out  1  MAR load enable.
- mdr_in  out  1  MDR enable.
- mdr_read  out  1  MDR source select: 1 = memory data in, 0 = bus.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking the end of an access.
- err  out  1  timeout flag; sticky until the next access is accepted.

## Operation
- All outputs are Moore outputs decoded from registered state. There is no combinational path from input to output.
- States: IDLE, LOAD_MAR, WR_MDR, RD_WAIT, RD_CAP, WR_WAIT, DONE.
- IDLE:
  - rd_req=1 goes to LOAD_MAR with the operation latched as read.
  - Otherwise, wr_req=1 goes to LOAD_MAR with the operation latched as write.
  - If both are high, the read wins and the write is ignored; it is re-sampled on the next IDLE.
- LOAD_MAR: mar_in=1. The control unit drives the address on the bus in this cycle. Next state is RD_WAIT (read) or WR_MDR (write).
- WR_MDR: mdr_in=1, mdr_read=0. The control unit drives write data on the bus. Next state is WR_WAIT.
- RD_WAIT: mem_read=1.
  - mem_ready=1 goes to RD_CAP.
  - Otherwise the wait counter increments.
- RD_CAP: mem_read=1, mdr_in=1, mdr_read=1; MDR captures memory data. Next state is DONE.
- WR_WAIT: mem_write=1.
  - mem_ready=1 goes to DONE.
  - Otherwise the wait counter increments.
- DONE: done=1. Next state is IDLE.
- Latched operation: request lines are ignored outside IDLE. Dropping a request mid-access does not abort it.
- Back-to-back: if a request is still high in the IDLE cycle after DONE, a new access starts. The control unit must deassert its request on seeing done.
- Wait counter:
  - Width is $clog2(TIMEOUT+1).
  - Cleared on entry to RD_WAIT or WR_WAIT.
  - Never wraps; it saturates at TIMEOUT.
- err is cleared when a new request is accepted in IDLE.

## Timing
- Reset: asynchronous on clear_n low. State goes to IDLE; counter and err go to 0; every output is 0 in the same instant, including mid-access.
- Reset release: the first edge with clear_n high may accept a request.
- Cycle numbering: the accepting edge is E0; C1 is the first cycle after E0.
- Read with zero wait states: C1 LOAD_MAR, C2 RD_WAIT (ready high), C3 RD_CAP, C4 DONE.
- Write with zero wait states: C1 LOAD_MAR, C2 WR_MDR, C3 WR_WAIT (ready high), C4 DONE.
- N wait cycles (ready low) add N cycles, so done is high in cycle 4+N.
- Each strobe is held continuously from its first asserted cycle until the cycle mem_ready is sampled high. For reads, mem_read stays high through RD_CAP.

## Configuration
- Macro MEM_SEQ_TIMEOUT_EN controls the timeout.
- Defined:
  - When the counter reaches TIMEOUT with mem_ready still low, the next state is DONE and err is set.
  - A read does not pass through RD_CAP, so MDR is not written.
  - If mem_ready is high in the same cycle the limit is reached, ready wins: normal completion, err=0.
- Undefined:
  - The wait states wait indefinitely.
  - The counter is not instantiated.
  - err is tied to 0.

## Test plan
- Read, mem_ready held high, rd_req pulsed at E0:
  - mar_in in C1, mem_read in C2–C3, mdr_in=mdr_read=1 in C3, done in C4, busy C1–C4.
- Write with 3 wait cycles:
  - mdr_in=1 and mdr_read=0 in C2.
  - mem_write in C3–C6, with ready raised in C6.
  - done in C7, err=0.
- rd_req and wr_req high together at E0:
  - The read sequence runs and mem_write is never asserted.
  - With wr_req kept high after done, a write starts at the following IDLE.
- Timeout (macro defined, TIMEOUT=4), read with mem_ready always low:
  - RD_WAIT lasts 4 cycles, then DONE with err=1 and no mdr_in pulse.
  - The next accepted request clears err.
- clear_n pulsed low during WR_WAIT:
  - All outputs drop to 0 immediately and the state is IDLE.
  - A read issued after release completes normally in 4 cycles.
